// File: rtl/awb_gain_ctrl.sv
// Auto-white-balance gain controller: per-frame R/G/B statistics -> gray-world / perfect-reflector gains.
// Latency: frame_end -> pending gains after 2*(SUM_WIDTH+8)+3 cycles; committed to gain_* on the next frame_start.
// Backpressure: none; a frame_start during computation aborts it and re-commits the previous pending gains.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   frame_start, frame_end         single-cycle frame boundary pulses
//   pixel_valid, pixel_r/g/b       pixel stream shared with the white-balance datapath
//   method                         00 manual, 01 gray world, 10 perfect reflector, 11 hold (sampled at frame_start)
//   manual_r/g/b                   gains used in manual mode (8.8 unsigned)
//   gain_r/g/b, gains_valid        registered gains to the datapath, one-cycle pulse when they are (re)loaded
//   busy                           high while a frame-end computation is in progress
module awb_gain_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int GAIN_WIDTH = 16,
  parameter int SUM_WIDTH  = 32,
  parameter logic [GAIN_WIDTH-1:0] GAIN_MIN = 16'h0040,
  parameter logic [GAIN_WIDTH-1:0] GAIN_MAX = 16'h0400
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  frame_end,
  input  logic                  pixel_valid,
  input  logic [DATA_WIDTH-1:0] pixel_r,
  input  logic [DATA_WIDTH-1:0] pixel_g,
  input  logic [DATA_WIDTH-1:0] pixel_b,
  input  logic [1:0]            method,
  input  logic [GAIN_WIDTH-1:0] manual_r,
  input  logic [GAIN_WIDTH-1:0] manual_g,
  input  logic [GAIN_WIDTH-1:0] manual_b,
  output logic [GAIN_WIDTH-1:0] gain_r,
  output logic [GAIN_WIDTH-1:0] gain_g,
  output logic [GAIN_WIDTH-1:0] gain_b,
  output logic                  gains_valid,
  output logic                  busy
);

  // Numerator is a sum shifted left by 8 (8.8 result), so the divider runs one bit per numerator bit.
  localparam int NW = SUM_WIDTH + 8;
  localparam int CW = $clog2(NW);
  localparam logic [CW-1:0]         CNT_LAST = CW'(NW - 1);
  localparam logic [GAIN_WIDTH-1:0] UNITY    = GAIN_WIDTH'(256);
  localparam logic [NW-1:0]         MIN_EXT  = NW'(GAIN_MIN);
  localparam logic [NW-1:0]         MAX_EXT  = NW'(GAIN_MAX);

  typedef enum logic [2:0] {IDLE, ACCUM, LATCH, DIV_R, DIV_B, DONE} state_t;

  state_t                state;
  logic [1:0]            method_q;
  logic [SUM_WIDTH-1:0]  sum_r, sum_g, sum_b;
  logic [DATA_WIDTH-1:0] max_r, max_g, max_b;
  logic [GAIN_WIDTH-1:0] pending_r, pending_g, pending_b;
  logic [GAIN_WIDTH-1:0] res_r, res_b;

  // Shared restoring divider
  logic [NW-1:0]         div_num;
  logic [SUM_WIDTH-1:0]  div_den;
  logic [SUM_WIDTH-1:0]  div_rem;
  logic [NW-1:0]         div_quo;
  logic [CW-1:0]         div_cnt;

  logic [NW-1:0]         op_num;
  logic [SUM_WIDTH-1:0]  op_den_r, op_den_b;
  logic [SUM_WIDTH:0]    rem_sh;
  logic                  rem_ge;
  logic [SUM_WIDTH-1:0]  rem_nxt;
  logic [NW-1:0]         quo_nxt;
  logic [GAIN_WIDTH-1:0] div_gain;

  function automatic logic [SUM_WIDTH-1:0] sat_add(input logic [SUM_WIDTH-1:0] s,
                                                   input logic [DATA_WIDTH-1:0] p);
    logic [SUM_WIDTH:0] t;
    t = {1'b0, s} + (SUM_WIDTH+1)'(p);
    return t[SUM_WIDTH] ? '1 : t[SUM_WIDTH-1:0];
  endfunction

  // Divider operands; sums and maxima are frozen outside ACCUM, so the B operands
  // can be taken straight from them when DIV_R finishes.
  always_comb begin
    op_num   = {sum_g, 8'h00};
    op_den_r = sum_r;
    op_den_b = sum_b;
    if (method_q == 2'b10) begin
      op_num   = {SUM_WIDTH'(max_g), 8'h00};
      op_den_r = SUM_WIDTH'(max_r);
      op_den_b = SUM_WIDTH'(max_b);
    end
  end

  // One restoring step. The remainder always stays below the divisor, so the
  // shifted value fits SUM_WIDTH+1 bits and the difference fits SUM_WIDTH bits.
  always_comb begin
    rem_sh  = {div_rem, div_num[NW-1]};
    rem_ge  = (rem_sh >= {1'b0, div_den});
    rem_nxt = rem_ge ? (rem_sh[SUM_WIDTH-1:0] - div_den) : rem_sh[SUM_WIDTH-1:0];
    quo_nxt = {div_quo[NW-2:0], rem_ge};
    if (div_den == '0)
      div_gain = UNITY;
    else if (quo_nxt > MAX_EXT)
      div_gain = GAIN_MAX;
    else if (quo_nxt < MIN_EXT)
      div_gain = GAIN_MIN;
    else
      div_gain = quo_nxt[GAIN_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      method_q    <= 2'b00;
      sum_r       <= '0;
      sum_g       <= '0;
      sum_b       <= '0;
      max_r       <= '0;
      max_g       <= '0;
      max_b       <= '0;
      pending_r   <= UNITY;
      pending_g   <= UNITY;
      pending_b   <= UNITY;
      res_r       <= UNITY;
      res_b       <= UNITY;
      gain_r      <= UNITY;
      gain_g      <= UNITY;
      gain_b      <= UNITY;
      gains_valid <= 1'b0;
      busy        <= 1'b0;
      div_num     <= '0;
      div_den     <= '0;
      div_rem     <= '0;
      div_quo     <= '0;
      div_cnt     <= '0;
    end else begin
      gains_valid <= 1'b0;
      if (frame_start) begin
        // Frame boundary wins over everything, including an in-flight computation.
        gain_r      <= pending_r;
        gain_g      <= pending_g;
        gain_b      <= pending_b;
        gains_valid <= 1'b1;
        method_q    <= method;
        busy        <= 1'b0;
        state       <= ACCUM;
        if (pixel_valid) begin
          sum_r <= SUM_WIDTH'(pixel_r);
          sum_g <= SUM_WIDTH'(pixel_g);
          sum_b <= SUM_WIDTH'(pixel_b);
          max_r <= pixel_r;
          max_g <= pixel_g;
          max_b <= pixel_b;
        end else begin
          sum_r <= '0;
          sum_g <= '0;
          sum_b <= '0;
          max_r <= '0;
          max_g <= '0;
          max_b <= '0;
        end
      end else begin
        case (state)
          IDLE: ;
          ACCUM: begin
            if (pixel_valid) begin
              sum_r <= sat_add(sum_r, pixel_r);
              sum_g <= sat_add(sum_g, pixel_g);
              sum_b <= sat_add(sum_b, pixel_b);
              max_r <= (pixel_r > max_r) ? pixel_r : max_r;
              max_g <= (pixel_g > max_g) ? pixel_g : max_g;
              max_b <= (pixel_b > max_b) ? pixel_b : max_b;
            end
            if (frame_end) begin
              state <= LATCH;
              busy  <= 1'b1;
            end
          end
          LATCH: begin
            case (method_q)
              2'b00: begin
                pending_r <= manual_r;
                pending_g <= manual_g;
                pending_b <= manual_b;
                state     <= DONE;
              end
              2'b11: state <= DONE;
              default: begin
                div_num <= op_num;
                div_den <= op_den_r;
                div_rem <= '0;
                div_quo <= '0;
                div_cnt <= '0;
                state   <= DIV_R;
              end
            endcase
          end
          DIV_R: begin
            if (div_cnt == CNT_LAST) begin
              res_r   <= div_gain;
              div_num <= op_num;
              div_den <= op_den_b;
              div_rem <= '0;
              div_quo <= '0;
              div_cnt <= '0;
              state   <= DIV_B;
            end else begin
              div_num <= {div_num[NW-2:0], 1'b0};
              div_rem <= rem_nxt;
              div_quo <= quo_nxt;
              div_cnt <= div_cnt + CW'(1);
            end
          end
          DIV_B: begin
            if (div_cnt == CNT_LAST) begin
              res_b <= div_gain;
              state <= DONE;
            end else begin
              div_num <= {div_num[NW-2:0], 1'b0};
              div_rem <= rem_nxt;
              div_quo <= quo_nxt;
              div_cnt <= div_cnt + CW'(1);
            end
          end
          DONE: begin
            // Computed gains land in pending only here, so an abort anywhere
            // earlier leaves the previous pending set untouched.
            if (method_q == 2'b01 || method_q == 2'b10) begin
              pending_r <= res_r;
              pending_g <= UNITY;
              pending_b <= res_b;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_awb_gain_ctrl.sv
module tb_awb_gain_ctrl;

  localparam int NW = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        frame_end = 1'b0;
  logic        pixel_valid = 1'b0;
  logic [7:0]  pixel_r = 8'h00, pixel_g = 8'h00, pixel_b = 8'h00;
  logic [1:0]  method = 2'b00;
  logic [15:0] manual_r = 16'h0100, manual_g = 16'h0100, manual_b = 16'h0100;
  logic [15:0] gain_r, gain_g, gain_b;
  logic        gains_valid, busy;

  awb_gain_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .frame_start(frame_start), .frame_end(frame_end),
    .pixel_valid(pixel_valid), .pixel_r(pixel_r), .pixel_g(pixel_g), .pixel_b(pixel_b),
    .method(method), .manual_r(manual_r), .manual_g(manual_g), .manual_b(manual_b),
    .gain_r(gain_r), .gain_g(gain_g), .gain_b(gain_b),
    .gains_valid(gains_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [47:0] exp_q[$];      // expected {r,g,b} per frame_start commit
  logic [23:0] pix_q[$];      // pixels for the next frame
  int unsigned mp_r = 256, mp_g = 256, mp_b = 256;   // model pending gains
  int unsigned s_r, s_g, s_b, m_r, m_g, m_b;          // model frame statistics

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  logic [47:0] last_gain = {16'd256, 16'd256, 16'd256};
  bit          prev_gv = 1'b0;
  always @(negedge clk) begin
    logic [47:0] e;
    if (!rst_n) begin
      last_gain = {16'd256, 16'd256, 16'd256};
      prev_gv   = 1'b0;
    end else begin
      if (gains_valid) begin
        check("gains_valid_single_cycle", prev_gv, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_gains_valid: got pulse expected none at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("commit_gain_r", gain_r, e[47:32]);
          check("commit_gain_g", gain_g, e[31:16]);
          check("commit_gain_b", gain_b, e[15:0]);
          last_gain = e;
        end
      end else begin
        check("gain_stable", {gain_r, gain_g, gain_b}, last_gain);
      end
      prev_gv = gains_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic int unsigned mgain(input longint unsigned num, input longint unsigned den);
    longint unsigned q;
    if (den == 0) return 256;
    q = (num * 256) / den;
    if (q < 64) return 64;
    if (q > 1024) return 1024;
    return int'(q);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    frame_start = 1'b0;
    frame_end   = 1'b0;
    pixel_valid = 1'b0;
    pixel_r     = 8'($urandom);
    pixel_g     = 8'($urandom);
    pixel_b     = 8'($urandom);
    method      = 2'($urandom_range(0, 3));
  endtask

  task automatic drive_pix();
    logic [23:0] p;
    p = pix_q.pop_front();
    pixel_valid = 1'b1;
    pixel_r = p[23:16];
    pixel_g = p[15:8];
    pixel_b = p[7:0];
    s_r += p[23:16];
    s_g += p[15:8];
    s_b += p[7:0];
    if (p[23:16] > m_r) m_r = p[23:16];
    if (p[15:8]  > m_g) m_g = p[15:8];
    if (p[7:0]   > m_b) m_b = p[7:0];
  endtask

  // One frame: frame_start, pixels from pix_q, frame_end, then gap-1 blanking
  // cycles; returns on the cycle where the next frame_start may be driven.
  task automatic run_frame(input logic [1:0] m, input int gap, input bit fs_pix, input bit fe_pix);
    int L;
    logic [15:0] mr, mg, mb;
    mr = manual_r; mg = manual_g; mb = manual_b;
    idle_inputs();
    frame_start = 1'b1;
    method = m;
    exp_q.push_back({mp_r[15:0], mp_g[15:0], mp_b[15:0]});
    s_r = 0; s_g = 0; s_b = 0; m_r = 0; m_g = 0; m_b = 0;
    if (fs_pix && pix_q.size() > 0) drive_pix();
    tick();
    while (pix_q.size() > (fe_pix ? 1 : 0)) begin
      check("busy_in_frame", busy, 0);
      idle_inputs();
      if ($urandom_range(0, 3) != 0) drive_pix();
      tick();
    end
    check("busy_in_frame", busy, 0);
    idle_inputs();
    frame_end = 1'b1;
    if (pix_q.size() > 0) drive_pix();
    tick();
    L = (m == 2'b01 || m == 2'b10) ? 2 * NW + 2 : 2;
    for (int k = 1; k < gap; k++) begin
      check("busy_blanking", busy, (k <= L) ? 1 : 0);
      idle_inputs();
      pixel_valid = 1'($urandom_range(0, 1));
      frame_end   = ($urandom_range(0, 7) == 0);
      tick();
    end
    check("busy_blanking", busy, (gap <= L) ? 1 : 0);
    if (m == 2'b00 && gap >= 2) begin
      mp_r = mr; mp_g = mg; mp_b = mb;
    end else if (m == 2'b01 && gap >= 2 * NW + 3) begin
      mp_r = mgain(s_g, s_r); mp_g = 256; mp_b = mgain(s_g, s_b);
    end else if (m == 2'b10 && gap >= 2 * NW + 3) begin
      mp_r = mgain(m_g, m_r); mp_g = 256; mp_b = mgain(m_g, m_b);
    end
  endtask

  task automatic push_n(input int n, input logic [23:0] p);
    for (int i = 0; i < n; i++) pix_q.push_back(p);
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) pix_q.push_back(24'($urandom));
  endtask

  initial begin
    // Reset state
    idle_inputs();
    repeat (3) tick();
    check("reset_gain_r", gain_r, 16'h0100);
    check("reset_gain_g", gain_g, 16'h0100);
    check("reset_gain_b", gain_b, 16'h0100);
    check("reset_gains_valid", gains_valid, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Gray world: expect 0x200 / 0x100 / 0x400
    push_n(16, {8'd64, 8'd128, 8'd32});
    run_frame(2'b01, 90, 1'b0, 1'b0);
    // Perfect reflector with clamp: expect 0x080 / 0x100 / 0x400
    pix_q.push_back({8'd200, 8'd100, 8'd10});
    pix_q.push_back({8'd100, 8'd50, 8'd5});
    run_frame(2'b10, 90, 1'b0, 1'b0);
    // Zero red channel -> unity
    push_n(5, {8'd0, 8'd50, 8'd50});
    run_frame(2'b01, 90, 1'b1, 1'b1);
    // Manual, then hold re-commits it
    manual_r = 16'h0123; manual_g = 16'h0100; manual_b = 16'h0345;
    push_rand(3);
    run_frame(2'b00, 90, 1'b0, 1'b0);
    push_rand(4);
    run_frame(2'b11, 90, 1'b0, 1'b0);
    // Aborted gray-world frame, then a normal one
    push_rand(6);
    run_frame(2'b01, 20, 1'b0, 1'b1);
    push_n(4, {8'd30, 8'd60, 8'd90});
    run_frame(2'b01, 90, 1'b1, 1'b0);
    // Blanking boundary: one cycle short aborts, exact minimum completes
    push_rand(5);
    run_frame(2'b10, 2 * NW + 2, 1'b0, 1'b0);
    push_rand(5);
    run_frame(2'b01, 2 * NW + 3, 1'b0, 1'b0);
    manual_r = 16'h0321; manual_g = 16'h00f0; manual_b = 16'h0200;
    push_rand(2);
    run_frame(2'b00, 90, 1'b0, 1'b0);
    // Reset during DIV_R
    push_rand(7);
    run_frame(2'b01, 12, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midreset_gain_r", gain_r, 16'h0100);
    check("midreset_gain_g", gain_g, 16'h0100);
    check("midreset_gain_b", gain_b, 16'h0100);
    check("midreset_busy", busy, 0);
    check("midreset_gains_valid", gains_valid, 0);
    mp_r = 256; mp_g = 256; mp_b = 256;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    push_rand(8);
    run_frame(2'b01, 90, 1'b0, 1'b0);

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      int gap;
      push_rand($urandom_range(0, 20));
      manual_r = 16'($urandom); manual_g = 16'($urandom); manual_b = 16'($urandom);
      gap = ($urandom_range(0, 1) != 0) ? int'($urandom_range(83, 100)) : int'($urandom_range(2, 82));
      run_frame(2'($urandom_range(0, 3)), gap, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Final frame_start flushes the last pending set
    idle_inputs();
    frame_start = 1'b1;
    exp_q.push_back({mp_r[15:0], mp_g[15:0], mp_b[15:0]});
    tick();
    idle_inputs();
    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
